isr_mult: RTL and testbench
===========================

ISR_MULT -- requirements
Module: isr_mult

Interface
REQ-001 The block SHALL have parameter K, default 4, giving multiplier bits retired per cycle; legal values are 1, 2, 4, 8, 16 and 32.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new product; sampled on the rising edge.
REQ-005 The block SHALL have port mcand, input, 32 bits: unsigned multiplicand; sampled only when start=1.
REQ-006 The block SHALL have port mplier, input, 32 bits: unsigned multiplier; sampled only when start=1.
REQ-007 The block SHALL have port product, output, 64 bits: unsigned product; registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress; registered.
REQ-009 The block SHALL have port done, output, 1 bit: high while product holds a valid result; registered.

Function
REQ-010 The block SHALL compute product = mcand * mplier, unsigned, full 64 bits, with no truncation or overflow for any operand pair.
REQ-011 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-012 In any state, start=1 at a rising edge SHALL load the operands, clear the accumulator and the cycle counter, set busy=1 and done=0, and enter BUSY.
  - This makes start during BUSY an abort-and-restart.
  - This makes start during DONE a back-to-back operation.
REQ-013 Each BUSY cycle SHALL perform the following, with the shifts on the internal operand copies:
  - add (mcand_reg * low K bits of mplier_reg) to a 64-bit accumulator;
  - shift mcand_reg left by K into a 64-bit register;
  - shift mplier_reg right by K;
  - increment the counter.
REQ-014 After the 32/K-th BUSY cycle, the block SHALL register the accumulator into product, set done=1 and busy=0, and enter DONE.
  - Latency: start sampled at edge t implies done=1 after edge t+32/K (after t+8 at default K).
REQ-015 The block SHALL NOT take an early exit when mplier reaches zero; latency SHALL be fixed and data-independent.
REQ-016 In DONE, product and done SHALL hold until the next start or reset; operand input changes SHALL have no effect.
REQ-017 In IDLE with start=0, all outputs SHALL hold.
REQ-018 product SHALL change only on the edge on which done rises, or on reset.
  - product SHALL NOT change on start; the previous value stays readable until the new result lands.
REQ-019 busy and done SHALL never both be 1.
REQ-020 With K=32, BUSY SHALL last exactly one cycle.
REQ-021 An illegal K SHALL be rejected at elaboration.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for a clock edge, force the following:
  - state IDLE;
  - product=0, busy=0, done=0;
  - accumulator, operand registers and counter to 0.
REQ-023 Reset asserted mid-operation SHALL abandon the operation with no partial result visible.
REQ-024 Release of reset SHALL take effect at the next rising edge.
  - start high on the first edge after release SHALL be honoured.
REQ-025 With reset=0, start SHALL be ignored.

Verification
REQ-026 K=4, reset released, start with mcand=15, mplier=15 -> done rises exactly 8 cycles after start; product=225; busy=0.
REQ-027 start with mcand=32'hFFFF_FFFF, mplier=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001.
REQ-028 start with mcand=0, mplier=32'hDEAD_BEEF -> product=0, still after 8 cycles.
REQ-029 Restart while busy:
  - start with 38*38;
  - 3 cycles later, start with 46*46;
  - required: no done for the first operation; done 8 cycles after the second start; product=2116.
REQ-030 Reset mid-operation:
  - start with 64*64;
  - pull reset low 4 cycles later, asynchronously between edges;
  - required: product=0, busy=0, done=0 immediately;
  - release reset, then start with 17*17 -> product=289.
REQ-031 Back-to-back and random coverage:
  - start asserted on the cycle done is high, for 1000 random operand pairs at K=1, 4 and 32;
  - each product SHALL match the reference multiply;
  - latency SHALL be 32/K;
  - busy/done SHALL stay mutually exclusive.

Source files
------------

// File: rtl/isr_mult_if.sv
// isr_mult_if
//   Bundles the request/result signals of the iterative shift-and-add
//   multiplier so the requester and the multiplier connect through a single
//   port each.
//   Signals:
//     start   - request a new product (requester -> multiplier)
//     mcand   - 32-bit unsigned multiplicand, valid with start
//     mplier  - 32-bit unsigned multiplier, valid with start
//     product - 64-bit unsigned result, valid while done is high
//     busy    - an operation is in progress
//     done    - product holds a valid result
//   Modports: master (requester side), slave (multiplier side).

interface isr_mult_if;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] product;
    logic        busy;
    logic        done;

    modport master (
        output start, mcand, mplier,
        input  product, busy, done
    );

    modport slave (
        input  start, mcand, mplier,
        output product, busy, done
    );
endinterface

// File: rtl/isr_mult.sv
// isr_mult
//   Unsigned 32x32 -> 64 iterative multiplier that retires K multiplier bits
//   per clock. Latency from the sampled start edge to done is a fixed 32/K
//   cycles regardless of operand values.
//   Parameters:
//     K       - multiplier bits retired per cycle: 1, 2, 4, 8, 16 or 32
//   Ports:
//     clock   - rising-edge clock
//     reset   - asynchronous, active-low reset
//     bus     - isr_mult_if slave: start/mcand/mplier in, product/busy/done out

module isr_mult #(
    parameter int K = 4
) (
    input  logic      clock,
    input  logic      reset,
    isr_mult_if.slave bus
);

    localparam int STEPS = 32 / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    // Any K that does not divide the 32-bit multiplier into whole digits is refused
    generate
        if (K != 1 && K != 2 && K != 4 && K != 8 && K != 16 && K != 32) begin : gen_bad_k
            $error("isr_mult: K must be one of 1, 2, 4, 8, 16, 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [63:0]   acc;
    logic [63:0]   mcand_reg;
    logic [31:0]   mplier_reg;
    logic [CW-1:0] count;
    logic [63:0]   product_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [63:0]   partial;
    logic [63:0]   acc_next;

    // One K-bit digit of the multiplier times the (already shifted) multiplicand;
    // the 64-bit accumulator can never overflow because the full product fits.
    always_comb begin
        partial  = mcand_reg * 64'(mplier_reg[K-1:0]);
        acc_next = acc + partial;
    end

    // start wins in every state, so it doubles as abort-and-restart while BUSY
    // and as back-to-back issue from DONE. product is only written on the edge
    // that finishes an operation, leaving the previous result readable meanwhile.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            count       <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (bus.start) begin
            state      <= BUSY;
            acc        <= '0;
            mcand_reg  <= {32'b0, bus.mcand};
            mplier_reg <= bus.mplier;
            count      <= '0;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    acc        <= acc_next;
                    mcand_reg  <= mcand_reg << K;
                    mplier_reg <= mplier_reg >> K;
                    count      <= count + 1'b1;
                    if (count == LAST) begin
                        product_reg <= acc_next;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state       <= DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.product = product_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;

endmodule

// File: tb/tb_isr_mult.sv
// tb_isr_mult
//   Self-checking bench for isr_mult. Three instances (K = 1, 4, 32) share a
//   clock and reset; directed scenarios run on the K=4 instance, then random
//   back-to-back operands run on all three. Expected products are pushed to a
//   scoreboard queue when start is driven and popped when done is observed.

module tb_isr_mult;

    logic clock;
    logic reset;

    isr_mult_if ifc_k1 ();
    isr_mult_if ifc_k4 ();
    isr_mult_if ifc_k32 ();

    isr_mult #(.K(1))  dut_k1  (.clock(clock), .reset(reset), .bus(ifc_k1));
    isr_mult #(.K(4))  dut_k4  (.clock(clock), .reset(reset), .bus(ifc_k4));
    isr_mult #(.K(32)) dut_k32 (.clock(clock), .reset(reset), .bus(ifc_k32));

    int          checkCount;
    int          passCount;
    int          failCount;
    logic [63:0] sb [$];
    logic [63:0] lastProd [3];

    // 100 MHz free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Instance selector: 0 -> K=1, 1 -> K=4, 2 -> K=32
    function automatic int latencyOf(input int sel);
        case (sel)
            0:       return 32;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] getProduct(input int sel);
        case (sel)
            0:       return ifc_k1.product;
            1:       return ifc_k4.product;
            default: return ifc_k32.product;
        endcase
    endfunction

    // {busy, done}
    function automatic logic [1:0] getStatus(input int sel);
        case (sel)
            0:       return {ifc_k1.busy, ifc_k1.done};
            1:       return {ifc_k4.busy, ifc_k4.done};
            default: return {ifc_k32.busy, ifc_k32.done};
        endcase
    endfunction

    task automatic applyStimulus(input int sel, input logic s,
                                 input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0: begin
                ifc_k1.start = s; ifc_k1.mcand = a; ifc_k1.mplier = b;
            end
            1: begin
                ifc_k4.start = s; ifc_k4.mcand = a; ifc_k4.mplier = b;
            end
            default: begin
                ifc_k32.start = s; ifc_k32.mcand = a; ifc_k32.mplier = b;
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issue one operation at the next edge, then follow it to done. Operands are
    // scrambled right after start is sampled; while busy, the old product must
    // stay visible. Leaves time one step after the edge on which done rose, so a
    // following call issues back-to-back.
    task automatic runOp(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        int          lat;
        int          cycles;
        logic [63:0] expected;
        lat = latencyOf(sel);
        sb.push_back({32'b0, a} * {32'b0, b});
        applyStimulus(sel, 1'b1, a, b);
        @(posedge clock); #1;
        applyStimulus(sel, 1'b0, $urandom, $urandom);
        cycles = 0;
        while (getStatus(sel) != 2'b01 && cycles < lat + 4) begin
            checkOutput({tag, " busy/done"}, 64'(getStatus(sel)), 64'(2'b10));
            checkOutput({tag, " product held"}, getProduct(sel), lastProd[sel]);
            @(posedge clock); #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, 64'(cycles), 64'(lat));
        checkOutput({tag, " done status"}, 64'(getStatus(sel)), 64'(2'b01));
        expected = sb.pop_front();
        checkOutput({tag, " product"}, getProduct(sel), expected);
        lastProd[sel] = expected;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        foreach (lastProd[i]) lastProd[i] = '0;

        // Reset asserted from time zero: all outputs cleared before any edge
        reset = 1'b0;
        for (int s = 0; s < 3; s++) applyStimulus(s, 1'b0, 32'd0, 32'd0);
        #2;
        for (int s = 0; s < 3; s++) begin
            checkOutput("reset product", getProduct(s), 64'd0);
            checkOutput("reset status", 64'(getStatus(s)), 64'd0);
        end

        // start is ignored while reset is held
        applyStimulus(1, 1'b1, 32'd15, 32'd15);
        @(posedge clock); #1;
        checkOutput("start during reset", 64'(getStatus(1)), 64'd0);

        // Release between edges; start on the very next edge is honoured
        applyStimulus(1, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        runOp(1, 32'd15, 32'd15, "15x15");

        // DONE holds product and done while operands wiggle
        repeat (3) begin
            applyStimulus(1, 1'b0, $urandom, $urandom);
            @(posedge clock); #1;
            checkOutput("done hold product", getProduct(1), 64'd225);
            checkOutput("done hold status", 64'(getStatus(1)), 64'(2'b01));
        end

        runOp(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "max x max");
        runOp(1, 32'd0, 32'hDEAD_BEEF, "zero x deadbeef");

        // Abort 38x38 three edges in with 46x46; the first result never appears
        applyStimulus(1, 1'b1, 32'd38, 32'd38);
        @(posedge clock); #1;
        applyStimulus(1, 1'b0, $urandom, $urandom);
        repeat (2) begin
            @(posedge clock); #1;
            checkOutput("pre-restart status", 64'(getStatus(1)), 64'(2'b10));
        end
        runOp(1, 32'd46, 32'd46, "restart 46x46");

        // Reset dropped between edges four cycles into 64x64
        applyStimulus(1, 1'b1, 32'd64, 32'd64);
        @(posedge clock); #1;
        applyStimulus(1, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async reset product", getProduct(1), 64'd0);
        checkOutput("async reset status", 64'(getStatus(1)), 64'd0);
        foreach (lastProd[i]) lastProd[i] = '0;
        @(posedge clock); #1;
        checkOutput("held reset status", 64'(getStatus(1)), 64'd0);
        reset = 1'b1;

        // IDLE with start low: outputs hold
        repeat (2) begin
            applyStimulus(1, 1'b0, $urandom, $urandom);
            @(posedge clock); #1;
            checkOutput("idle hold product", getProduct(1), 64'd0);
            checkOutput("idle hold status", 64'(getStatus(1)), 64'd0);
        end
        runOp(1, 32'd17, 32'd17, "17x17 after reset");

        // Random back-to-back traffic on every width
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1000; i++) begin
                runOp(s, $urandom, $urandom, "random");
            end
            applyStimulus(s, 1'b0, 32'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
